// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding and the default bus widths
// used by the APB requester and the GPIO/UART slaves.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_master.sv
// APB3 requester: one command at a time, IDLE->SETUP->ACCESS, single-cycle response.
// Optional ACCESS timeout is built only when APB_TIMEOUT_EN is defined.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_state_e        r_state;
  apb_state_e        w_next;
  logic              w_hs;
  logic              w_done;
  logic              w_abort;
  logic              w_cmd_ready;
  logic              w_psel;
  logic              w_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  assign w_hs   = cmd_valid && w_cmd_ready;
  assign w_done = (r_state == ACCESS) && pready;

`ifdef APB_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_err;

  // Counts completed ACCESS cycles; cleared in SETUP so it is zero on ACCESS entry.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_cnt <= '0;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A ready slave in the limit cycle still completes normally.
  assign w_abort = (r_state == ACCESS) && !pready && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_abort;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_abort = 1'b0;
  assign rsp_err = 1'b0;

  // TIMEOUT_CYCLES only shapes the timeout build; keep it referenced here.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_hs) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (w_done || w_abort) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // cmd_ready is gated by Reset because the async reset parks the FSM in IDLE.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    unique case (r_state)
      IDLE:   w_cmd_ready = !Reset;
      SETUP:  w_psel      = 1'b1;
      ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_hs) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_done || w_abort;
      if (w_done) begin
        r_rsp_rdata <= r_pwrite ? '0 : prdata;
      end else if (w_abort) begin
        r_rsp_rdata <= '0;
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign Psel      = w_psel;
  assign penable   = w_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: vector table, randomized transfers against
// a cycle-count model, and hand sequences for back-to-back, reset and timeout.
module tb_apb_master;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          Psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Psel(Psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ws;
    logic [DW-1:0] prd;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Number of ACCESS cycles a transfer occupies when the slave inserts ws wait states.
  function automatic int model_acc(input int ws);
`ifdef APB_TIMEOUT_EN
    if (ws >= TMO) return TMO;
`endif
    return ws + 1;
  endfunction

  function automatic logic model_err(input int ws);
`ifdef APB_TIMEOUT_EN
    return ws >= TMO;
`else
    return (ws < 0);
`endif
  endfunction

  // Returns at the falling edge after the accepting rising edge (the SETUP cycle).
  task automatic wait_accept(output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 10 && !ok) begin
      if (cmd_ready) ok = 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_xfer(input vec_t v, input string tag);
    int   k, rsp_k, rsp_n, psel_n, pen_n, acc, exp_acc;
    logic ok, stable, rdy_bad, got_err;
    logic [DW-1:0] got_rd;
    exp_acc   = model_acc(v.ws);
    cmd_valid = 1'b1;
    cmd_write = v.w;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    wait_accept(ok);
    chk({tag, "_accept"}, 64'(ok), 64'd1);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    k = 1; rsp_k = 0; rsp_n = 0; psel_n = 0; pen_n = 0; acc = 0;
    stable = 1'b1; rdy_bad = 1'b0; got_rd = '0; got_err = 1'b0;
    while ((rsp_n == 0 || k <= rsp_k + 1) && k <= 40) begin
      if (Psel) begin
        psel_n++;
        if (paddr !== v.addr || pwrite !== v.w || (v.w && pwdata !== v.wdata)) stable = 1'b0;
        if (cmd_ready) rdy_bad = 1'b1;
      end
      if (penable) pen_n++;
      if (rsp_valid) begin
        rsp_n++;
        rsp_k   = k;
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        if (!cmd_ready) rdy_bad = 1'b1;
      end
      if (Psel && penable) begin
        pready = (acc == v.ws);
        prdata = pready ? v.prd : $urandom;
        acc++;
      end else begin
        pready = 1'($urandom);
        prdata = $urandom;
      end
      @(negedge clk);
      k++;
    end
    pready = 1'b0;
    chk({tag, "_rsp_count"}, 64'(rsp_n), 64'd1);
    chk({tag, "_latency"}, 64'(rsp_k), 64'(exp_acc + 2));
    chk({tag, "_psel_cycles"}, 64'(psel_n), 64'(exp_acc + 1));
    chk({tag, "_penable_cycles"}, 64'(pen_n), 64'(exp_acc));
    chk({tag, "_rdata"}, 64'(got_rd), 64'(v.exp_rdata));
    chk({tag, "_err"}, 64'(got_err), 64'(v.exp_err));
    chk({tag, "_bus_stable"}, 64'(stable), 64'd1);
    chk({tag, "_cmd_ready_ok"}, 64'(rdy_bad), 64'd0);
  endtask

  vec_t tbl[5];
  vec_t rv;

  initial begin
    logic          ok;
    logic [6:1]    rsp_bits, rdy_bits, psel_bits;
    logic [AW-1:0] addr_k[1:6];
    int            seen;

    tbl[0] = '{1'b1, 5'h03, 32'hDEADBEEF, 0, 32'h0BADF00D, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 5'h03, 32'h0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b0, 5'h1F, 32'h0, 0, 32'h12345678, 32'h12345678, 1'b0};
    tbl[3] = '{1'b1, 5'h00, 32'hFFFFFFFF, 2, 32'hCAFEBABE, 32'h0, 1'b0};
    tbl[4] = '{1'b0, 5'h10, 32'h0, TMO - 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};

    // Reset held for three cycles: every output low, then ready right after release.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_ctrl", 64'({cmd_ready, rsp_valid, rsp_err, Psel, penable, pwrite}), 64'd0);
      chk("reset_data", 64'({rsp_rdata, paddr}), 64'd0);
      chk("reset_pwdata", 64'(pwdata), 64'd0);
    end
    Reset = 1'b0;
    #1;
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 5; i++) do_xfer(tbl[i], $sformatf("tbl%0d", i));

    // Back-to-back: cmd_valid held across two writes.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h01; cmd_wdata = 32'h11110001;
    wait_accept(ok);
    chk("b2b_accept", 64'(ok), 64'd1);
    cmd_addr = 5'h02; cmd_wdata = 32'h22220002;
    for (int k = 1; k <= 6; k++) begin
      rsp_bits[k]  = rsp_valid;
      rdy_bits[k]  = cmd_ready;
      psel_bits[k] = Psel;
      addr_k[k]    = paddr;
      pready = Psel && penable;
      prdata = $urandom;
      if (k == 4) cmd_valid = 1'b0;
      @(negedge clk);
    end
    pready = 1'b0;
    chk("b2b_rsp_pattern", 64'(rsp_bits), 64'(6'b100100));
    chk("b2b_ready_pattern", 64'(rdy_bits), 64'(6'b100100));
    chk("b2b_psel_pattern", 64'(psel_bits), 64'(6'b011011));
    chk("b2b_addr_first", 64'({addr_k[1], addr_k[2]}), 64'({5'h01, 5'h01}));
    chk("b2b_addr_second", 64'({addr_k[4], addr_k[5]}), 64'({5'h02, 5'h02}));

    // Reset pulse in the middle of ACCESS of a read.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h07;
    wait_accept(ok);
    cmd_valid = 1'b0; pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_in_access", 64'({Psel, penable}), 64'(2'b11));
    #2 Reset = 1'b1;
    #1;
    chk("rst_mid_bus_dropped", 64'({Psel, penable, cmd_ready}), 64'd0);
    @(negedge clk);
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen++;
      pready = 1'($urandom);
      @(negedge clk);
    end
    pready = 1'b0;
    chk("rst_mid_no_rsp", 64'(seen), 64'd0);
    chk("rst_mid_idle_ready", 64'(cmd_ready), 64'd1);
    rv = '{1'b0, 5'h07, 32'h0, 1, 32'h5A5A1234, 32'h5A5A1234, 1'b0};
    do_xfer(rv, "after_rst");

    // Slave that never becomes ready.
`ifdef APB_TIMEOUT_EN
    rv = '{1'b0, 5'h09, 32'h0, 1000, 32'h77777777, 32'h0, 1'b1};
    do_xfer(rv, "timeout");
`else
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h09;
    wait_accept(ok);
    cmd_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 101; i++) begin
      pready = 1'b0;
      prdata = $urandom;
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("stuck_still_access", 64'({Psel, penable}), 64'(2'b11));
    chk("stuck_no_rsp", 64'(seen), 64'd0);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
`endif

    // Randomized transfers against the model.
    for (int i = 0; i < 30; i++) begin
      rv.w     = 1'($urandom);
      rv.addr  = AW'($urandom);
      rv.wdata = $urandom;
`ifdef APB_TIMEOUT_EN
      rv.ws    = int'($urandom_range(0, TMO + 2));
`else
      rv.ws    = int'($urandom_range(0, 5));
`endif
      rv.prd       = $urandom;
      rv.exp_err   = model_err(rv.ws);
      rv.exp_rdata = (rv.w || rv.exp_err) ? '0 : rv.prd;
      do_xfer(rv, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
